// File: rtl/dc_stream_scoreboard.sv
// dc_stream_scoreboard: in-order shadow-FIFO scoreboard and valid/ready protocol checker for one pipeline stage
module dc_stream_scoreboard #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 64,
    parameter bit CHECK_IN = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       out_valid,
    input  logic                       out_ready,
    input  logic [WIDTH-1:0]           out_data,
    input  logic                       err_clear,
    output logic                       seq_error,
    output logic                       protocol_error,
    output logic                       overflow_error,
    output logic                       timeout_error,
    output logic                       any_error,
    output logic [$clog2(DEPTH+1)-1:0] in_flight,
    output logic [CNT_W-1:0]           xfer_count
);
    localparam int IW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] FULL = IW'(DEPTH);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             seq_q, seq_d, prot_q, prot_d, ovf_q, ovf_d, tmo_err_q, tmo_err_d;
    logic             out_stall_q, out_stall_d, in_stall_q, in_stall_d;
    logic [WIDTH-1:0] out_hold_q, out_hold_d, in_hold_q, in_hold_d;
    logic             push, pop, empty, full, bypass, st_push, st_pop;
    logic             seq_ev, ovf_ev, prot_ev, tmo_ev;

    // Classify this cycle's handshakes against the shadow FIFO and detect error events
    always_comb begin
        push    = in_valid & in_ready;
        pop     = out_valid & out_ready;
        empty   = cnt_q == '0;
        full    = cnt_q == FULL;
        bypass  = pop & push & empty;
        st_pop  = pop & ~empty;
        st_push = push & ~bypass & (~full | pop);
        seq_ev  = pop & (st_pop ? out_data != mem_q[rd_q] : (~push | out_data != in_data));
        ovf_ev  = push & full & ~pop;
        prot_ev = (out_stall_q & (~out_valid | out_data != out_hold_q))
                | (in_stall_q & (~in_valid | in_data != in_hold_q));
        tmo_d   = (TIMEOUT == 0 || pop || empty) ? '0 : (tmo_q == TMAX ? tmo_q : tmo_q + 1'b1);
        tmo_ev  = TIMEOUT != 0 && tmo_q != TMAX && tmo_d == TMAX;
    end

    // Next-state for pointers, occupancy, counters, stall history and sticky flags
    always_comb begin
        wr_d        = wr_q + PW'(st_push);
        rd_d        = rd_q + PW'(st_pop);
        cnt_d       = cnt_q + IW'(st_push) - IW'(st_pop);
        xfer_d      = (pop && xfer_q != '1) ? xfer_q + 1'b1 : xfer_q;
        out_stall_d = out_valid & ~out_ready;
        out_hold_d  = out_data;
        in_stall_d  = CHECK_IN & in_valid & ~in_ready;
        in_hold_d   = in_data;
        seq_d       = seq_ev | (seq_q & ~err_clear);
        prot_d      = prot_ev | (prot_q & ~err_clear);
        ovf_d       = ovf_ev | (ovf_q & ~err_clear);
        tmo_err_d   = tmo_ev | (tmo_err_q & ~err_clear);
    end

    // Tail write of accepted tokens into the shadow FIFO
    always_comb begin
        mem_d = mem_q;
        if (st_push) mem_d[wr_q] = in_data;
    end

    // Shadow FIFO storage; contents are only meaningful below the occupancy count, so no reset
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous active-low reset that discards everything in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            xfer_q      <= '0;
            out_stall_q <= 1'b0;
            out_hold_q  <= '0;
            in_stall_q  <= 1'b0;
            in_hold_q   <= '0;
            seq_q       <= 1'b0;
            prot_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            xfer_q      <= xfer_d;
            out_stall_q <= out_stall_d;
            out_hold_q  <= out_hold_d;
            in_stall_q  <= in_stall_d;
            in_hold_q   <= in_hold_d;
            seq_q       <= seq_d;
            prot_q      <= prot_d;
            ovf_q       <= ovf_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign seq_error      = seq_q;
    assign protocol_error = prot_q;
    assign overflow_error = ovf_q;
    assign timeout_error  = tmo_err_q;
    assign any_error      = seq_q | prot_q | ovf_q | tmo_err_q;
    assign in_flight      = cnt_q;
    assign xfer_count     = xfer_q;
endmodule
